// File: rtl/flood_pkg.sv
// rtl/flood_pkg.sv - shared constants, FSM encoding and helpers for the board generator
package flood_pkg;

  localparam int SIZE_MIN  = 2;
  localparam int SIZE_MAX  = 26;
  localparam int COLOR_MIN = 3;
  localparam int COLOR_MAX = 8;
  localparam int ADDR_W    = 10;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [4:0] clamp5(input logic [4:0] v, input logic [4:0] lo,
                                        input logic [4:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [3:0] clamp4(input logic [3:0] v, input logic [3:0] lo,
                                        input logic [3:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Scale an 8-bit random byte into 0..c-1: top bits of the 8x4 product
  function automatic logic [2:0] pick_color(input logic [7:0] r, input logic [3:0] c);
    return 3'(({4'b0, r} * {8'b0, c}) >> 8);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR
module lfsr16
  import flood_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        MASTER_CLOCK,
  input  logic        RESET,
  output logic [15:0] state
);

  logic [15:0] state_q;

  // Advance every cycle; reload the seed on reset
  always_ff @(posedge MASTER_CLOCK) begin
    if (RESET) begin
      state_q <= SEED;
    end else begin
      state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/board_gen.sv
// rtl/board_gen.sv - fills the board RAM with random colours, one cell per cycle
module board_gen #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          SIZE_MAX = 26,
  parameter int          SIZE_MIN = 2
) (
  input  logic       MASTER_CLOCK,
  input  logic       RESET,
  input  logic       INITIALIZE_BOARD,
  input  logic [4:0] SIZE,
  input  logic [3:0] COLOR_NUM,
  output logic       BOARD_READY,
  output logic       WR_EN,
  output logic [9:0] WR_ADDR,
  output logic [2:0] WR_DATA,
  output logic [2:0] FIRST_COLOR
);

  import flood_pkg::*;

  localparam logic [4:0] S_MIN = 5'(SIZE_MIN);
  localparam logic [4:0] S_MAX = 5'(SIZE_MAX);
  localparam logic [3:0] C_MIN = 4'(COLOR_MIN);
  localparam logic [3:0] C_MAX = 4'(COLOR_MAX);

  logic [15:0] lfsr;
  logic        lfsr_unused;

  state_t      state_q, state_n;
  logic [4:0]  s_q, s_n;
  logic [3:0]  c_q, c_n;
  logic [4:0]  row_q, row_n;
  logic [4:0]  col_q, col_n;
  logic        wr_en_q, wr_en_n;
  logic [2:0]  wr_data_q, wr_data_n;
  logic        ready_q, ready_n;
  logic [2:0]  first_q, first_n;
  logic [4:0]  last_idx;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .MASTER_CLOCK(MASTER_CLOCK),
    .RESET       (RESET),
    .state       (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:8];
  assign last_idx    = s_q - 5'd1;

  // State and registered outputs; reset overrides everything
  always_ff @(posedge MASTER_CLOCK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      s_q       <= S_MIN;
      c_q       <= C_MIN;
      row_q     <= '0;
      col_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      first_q   <= '0;
    end else begin
      state_q   <= state_n;
      s_q       <= s_n;
      c_q       <= c_n;
      row_q     <= row_n;
      col_q     <= col_n;
      wr_en_q   <= wr_en_n;
      wr_data_q <= wr_data_n;
      ready_q   <= ready_n;
      first_q   <= first_n;
    end
  end

  // Next state: the cell presented on the outputs is the one being written this cycle
  always_comb begin
    state_n   = state_q;
    s_n       = s_q;
    c_n       = c_q;
    row_n     = row_q;
    col_n     = col_q;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data_q;
    ready_n   = 1'b0;
    first_n   = first_q;
    case (state_q)
      ST_IDLE: begin
        if (INITIALIZE_BOARD) begin
          s_n       = clamp5(SIZE, S_MIN, S_MAX);
          c_n       = clamp4(COLOR_NUM, C_MIN, C_MAX);
          row_n     = '0;
          col_n     = '0;
          wr_en_n   = 1'b1;
          wr_data_n = pick_color(lfsr[7:0], c_n);
          first_n   = wr_data_n;
          state_n   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!INITIALIZE_BOARD) begin
          state_n = ST_IDLE;
        end else if (row_q == last_idx && col_q == last_idx) begin
          ready_n = 1'b1;
          state_n = ST_DONE;
        end else begin
          if (col_q == last_idx) begin
            col_n = '0;
            row_n = row_q + 5'd1;
          end else begin
            col_n = col_q + 5'd1;
          end
          wr_en_n   = 1'b1;
          wr_data_n = pick_color(lfsr[7:0], c_q);
        end
      end
      ST_DONE: begin
        if (INITIALIZE_BOARD) begin
          ready_n = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign BOARD_READY = ready_q;
  assign WR_EN       = wr_en_q;
  assign WR_ADDR     = {row_q, col_q};
  assign WR_DATA     = wr_data_q;
  assign FIRST_COLOR = first_q;

endmodule

// File: doc/board_gen.md
BOARD_GEN -- requirements
Module: board_gen

Interface
REQ-001 Parameter: SEED, 16'hACE1, LFSR value loaded at reset; SHALL be nonzero.
REQ-002 Parameter: SIZE_MAX, 26, largest legal board edge; SIZE_MIN, 2, smallest legal board edge.
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-004 MASTER_CLOCK  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 INITIALIZE_BOARD  input  1  level request from select; held high until BOARD_READY is seen.
REQ-007 SIZE  input  5  board edge length in cells.
REQ-008 COLOR_NUM  input  4  number of colours in play.
REQ-009 BOARD_READY  output  1  board fully written; held until INITIALIZE_BOARD falls.
REQ-010 WR_EN  output  1  board RAM write strobe, one cell per cycle.
REQ-011 WR_ADDR  output  10  cell address {row[4:0], col[4:0]}.
REQ-012 WR_DATA  output  3  cell colour index.
REQ-013 FIRST_COLOR  output  3  colour written to cell (0,0), the flood origin colour.

Function
REQ-014 The LFSR SHALL be a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that advances every cycle regardless of state, so user timing seeds the board.
REQ-015 The FSM SHALL have states IDLE, FILL and DONE.
REQ-016 In IDLE, when INITIALIZE_BOARD=1 is sampled, the FSM SHALL latch the clamped S and C, clear row and col, and go to FILL.
REQ-017 Clamping: S = SIZE limited to 2..26 and C = COLOR_NUM limited to 3..8, both taken from the IDLE-exit sample and frozen for the whole fill.
REQ-018 In FILL, WR_EN SHALL be 1 every cycle, with WR_ADDR={row,col} and WR_DATA=(lfsr[7:0]*C)>>8, an 8x4 product using bits [10:8] and guaranteed in 0..C-1.
REQ-019 Scan order SHALL be col increment; at col=S-1, col wraps to 0 and row increments; the write of (S-1,S-1) is last.
REQ-020 Latency: WR_EN SHALL be high for exactly S*S consecutive cycles, starting the cycle after INITIALIZE_BOARD was sampled in IDLE.
REQ-021 BOARD_READY SHALL rise in the cycle after the last write (DONE), with WR_EN=0.
REQ-022 In DONE, BOARD_READY SHALL stay 1 until INITIALIZE_BOARD=0 is sampled; it then falls the next cycle and the FSM returns to IDLE.
REQ-023 FIRST_COLOR SHALL update with the (0,0) write data and hold until the next (0,0) write.
REQ-024 Abort: if INITIALIZE_BOARD=0 is sampled in FILL, the FSM SHALL return to IDLE, WR_EN falls the next cycle, and BOARD_READY does not rise.
REQ-025 Changes to SIZE or COLOR_NUM during FILL or DONE SHALL be ignored.
REQ-026 WR_EN, WR_ADDR, WR_DATA, BOARD_READY and FIRST_COLOR SHALL all be registered outputs.

Reset
REQ-027 RESET SHALL force IDLE, LFSR=SEED, and WR_EN=0, WR_ADDR=0, WR_DATA=0, BOARD_READY=0, FIRST_COLOR=0, taking priority over all other inputs.
REQ-028 Reset mid-FILL SHALL stop writes the next cycle; a partial board is acceptable and no BOARD_READY is issued.

Structure
REQ-029 The shared package flood_pkg SHALL hold SIZE_MIN/SIZE_MAX, COLOR_MIN=3/COLOR_MAX=8, ADDR_W=10, the LFSR taps and the FSM state encoding.
REQ-030 The design SHALL use one sub-module, lfsr16 (enable-free, seed parameter, 16-bit state out).

Verification
REQ-031 Reset: assert RESET 3 cycles, with INITIALIZE_BOARD=1 held throughout -> all outputs 0, and WR_EN stays 0 while RESET is high.
REQ-032 Small board: SIZE=2, COLOR_NUM=3, INITIALIZE_BOARD raised -> exactly 4 writes to addresses 0,1,32,33 with WR_DATA<3; BOARD_READY rises the next cycle and holds until INITIALIZE_BOARD drops, then falls 1 cycle later.
REQ-033 Full board: SIZE=26, COLOR_NUM=8 -> 676 consecutive writes, last address 825; all values 0..7 appear; FIRST_COLOR equals the data of the address-0 write.
REQ-034 Clamp: SIZE=31, COLOR_NUM=1 -> 676 writes, all WR_DATA<3; SIZE=0 -> 4 writes.
REQ-035 Abort/reset: drop INITIALIZE_BOARD after 10 writes -> WR_EN low within 1 cycle and no BOARD_READY; repeat with RESET instead -> same, plus outputs cleared.
REQ-036 Mid-fill input change: SIZE changed 14->6 during FILL -> exactly 196 writes.
